seq_det_arbiter: RTL and testbench
==================================

SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing the detector.
REQ-002 Parameter LEN_W, 8, width of frame length and match count.
REQ-003 Parameter PATTERN, 4'b1101, bit pattern detected; first bit in time is the MSB.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 req  in  NREQ  per-requester request; held high for the whole frame.
REQ-007 din  in  NREQ  per-requester serial bit; only the granted lane is sampled.
REQ-008 len  in  LEN_W  frame length in bits; latched at grant.
REQ-009 gnt  out  NREQ  one-hot grant; high for every RUN cycle of the frame.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 match  out  1  one-cycle pulse; pattern completed by the bit sampled on the previous edge.
REQ-012 done  out  1  one-cycle frame-end pulse.
REQ-013 done_id  out  clog2(NREQ)  index of the finished requester; valid with done.
REQ-014 match_cnt  out  LEN_W  matches in the finished frame; valid with done.
REQ-015 abort  out  1  high with done when the frame ended early.

Function
REQ-016 FSM states: IDLE, RUN, DONE.
REQ-017 IDLE with any req bit high: on the next edge, grant the first requester at or after rr_ptr (round robin, wrapping).
- On the same edge: latch len into bit_cnt, clear the detector and match counter.
- Go to RUN, or go straight to DONE if len==0.
REQ-018 In RUN, each edge samples din[k] of the granted lane k.
- The sample feeds the detector.
- bit_cnt decrements.
- The last bit (bit_cnt==1) moves the FSM to DONE.
REQ-019 Detection is overlapping: after a match, the detector keeps the longest pattern suffix already matched.
- Example: 1101101 yields two matches.
REQ-020 On an edge whose sampled bit completes the pattern:
- match_cnt increments, saturating at all-ones.
- match is high for the following cycle.
- Detection latency is therefore one cycle.
REQ-021 req[k] low during RUN: on the next edge, go to DONE with abort=1.
- The bit present that cycle is not sampled.
REQ-022 DONE lasts exactly one cycle:
- done=1, gnt=0.
- done_id=k, match_cnt final, abort as set.
- rr_ptr becomes k+1 mod NREQ.
- Next state is IDLE.
REQ-023 A match on the frame's last bit is pulsed in the DONE cycle and is included in match_cnt.
REQ-024 At most one gnt bit is high at any time; gnt is never high in IDLE or DONE.
REQ-025 Changes to len or to other req bits during RUN have no effect on the current frame.
REQ-026 Minimum spacing between grants is three cycles: IDLE, RUN, DONE.

Reset
REQ-027 rst low at a clock edge forces all of the following regardless of state, including mid-RUN:
- state=IDLE, rr_ptr=0, bit_cnt=0, detector state cleared.
- gnt=0, busy=0, match=0, done=0, done_id=0, match_cnt=0, abort=0.
REQ-028 No done pulse is emitted for a frame cut off by reset.

Structure
REQ-029 Package seq_det_pkg holds:
- the state enum;
- NREQ, LEN_W and PATTERN defaults;
- the detector-state typedef.
REQ-030 Sub-module seq_det_core (serial overlapping pattern detector with a clear input) is instantiated once.
- All arbitration, counting and FSM logic live in seq_det_arbiter.

Verification
REQ-031 Basic frame: req=0001, len=7, din[0]=1,1,0,1,1,0,1.
- match pulses after bits 4 and 7.
- done with done_id=0, match_cnt=2, abort=0.
REQ-032 Round robin: after reset, req=0101 held continuously.
- Grants are 0,2,0,2.
- Each frame is separated by DONE and IDLE cycles.
REQ-033 Zero length: req=0010, len=0.
- gnt never asserts.
- done one cycle after leaving IDLE, with done_id=1, match_cnt=0.
REQ-034 Abort: req=0010, len=10, din=1,1,0, then req[1] dropped.
- Next cycle: done=1, abort=1, done_id=1, match_cnt=0.
REQ-035 Reset mid-frame: rst low during RUN bit 3.
- Next cycle: all outputs zero, no done.
- A fresh req=1000 is then granted, with rr_ptr starting from 0.
REQ-036 Saturation: LEN_W=4, len=15, din=1101 repeated with overlap.
- match_cnt counts correctly without wrap.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared types and defaults for the arbitrated serial pattern detector.
//   state_t      : arbiter FSM states
//   det_state_t  : detector history (last PAT_W-1 bits) plus fill level
//   *_DEF        : default parameter values for seq_det_arbiter
package seq_det_pkg;

    localparam int              NREQ_DEF    = 4;
    localparam int              LEN_W_DEF   = 8;
    localparam int              PAT_W       = 4;
    localparam logic [PAT_W-1:0] PATTERN_DEF = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // hist holds the most recent PAT_W-1 sampled bits (newest in the LSB);
    // fill counts how many of them belong to the current frame.
    typedef struct packed {
        logic [PAT_W-2:0]         hist;
        logic [$clog2(PAT_W)-1:0] fill;
    } det_state_t;

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core
// Serial overlapping pattern detector. The first bit in time is the MSB of
// PATTERN. Keeping a sliding window of the last PAT_W-1 bits means that after
// a match the longest already-matched suffix is retained automatically.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-low reset
//   clr    in  forget all history (start of a new frame)
//   en     in  bit_in is valid this cycle
//   bit_in in  serial data bit
//   hit    out combinational: this cycle's bit completes the pattern
module seq_det_core
    import seq_det_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    localparam logic [$clog2(PAT_W)-1:0] FILL_FULL = ($clog2(PAT_W))'(PAT_W - 1);

    det_state_t r_st;

    assign hit = en && (r_st.fill == FILL_FULL) && ({r_st.hist, bit_in} == PATTERN);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_st <= '0;
        end else if (en) begin
            r_st.hist <= {r_st.hist[PAT_W-3:0], bit_in};
            if (r_st.fill != FILL_FULL) begin
                r_st.fill <= r_st.fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter
// Round-robin arbiter that lends one serial pattern detector to NREQ
// requesters, one frame at a time, and reports per-frame match counts.
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-low reset
//   req       in   per-requester request, held for the whole frame
//   din       in   per-requester serial bit (granted lane sampled only)
//   len       in   frame length in bits, latched at grant
//   gnt       out  one-hot grant, high in RUN only
//   busy      out  FSM not in IDLE
//   match     out  one-cycle pulse after the bit completing the pattern
//   done      out  one-cycle frame-end pulse
//   done_id   out  index of the finished requester (valid with done)
//   match_cnt out  saturating match count of the frame (valid with done)
//   abort     out  frame ended because its req dropped (valid with done)
//
// state   | meaning
// IDLE    | waiting for any req; picks next requester round robin
// RUN     | sampling one bit per cycle from the granted lane
// DONE    | one-cycle report of the finished frame
module seq_det_arbiter
    import seq_det_pkg::*;
#(
    parameter int               NREQ    = NREQ_DEF,
    parameter int               LEN_W   = LEN_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         din,
    input  logic [LEN_W-1:0]        len,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    match,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [LEN_W-1:0]        match_cnt,
    output logic                    abort
);

    localparam int IW = $clog2(NREQ);

    state_t            r_state;
    logic [IW-1:0]     r_rr_ptr;
    logic [IW-1:0]     r_idx;
    logic [LEN_W-1:0]  r_bit_cnt;
    logic [LEN_W-1:0]  r_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic              r_match;
    logic              r_done;
    logic              r_abort;

    logic              w_found;
    logic [IW-1:0]     w_pick;
    logic              w_sample;
    logic              w_clr;
    logic              w_hit;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(r_rr_ptr) + i) % NREQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(idx);
            end
        end
    end

    // A dropped req ends the frame without sampling that cycle's bit.
    assign w_sample = (r_state == ST_RUN) && req[r_idx];
    assign w_clr    = (r_state == ST_IDLE);

    seq_det_core #(
        .PATTERN (PATTERN)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .en     (w_sample),
        .bit_in (din[r_idx]),
        .hit    (w_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_idx     <= '0;
            r_bit_cnt <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_match   <= 1'b0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_match <= 1'b0;
                    r_done  <= 1'b0;
                    r_abort <= 1'b0;
                    if (w_found) begin
                        r_idx     <= w_pick;
                        r_bit_cnt <= len;
                        r_cnt     <= '0;
                        if (len == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_gnt   <= '0;
                        end else begin
                            r_state <= ST_RUN;
                            r_gnt   <= NREQ'(1) << w_pick;
                        end
                    end
                end
                ST_RUN: begin
                    if (!req[r_idx]) begin
                        r_state <= ST_DONE;
                        r_gnt   <= '0;
                        r_match <= 1'b0;
                        r_done  <= 1'b1;
                        r_abort <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        r_match   <= w_hit;
                        if (w_hit && (r_cnt != '1)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_bit_cnt == LEN_W'(1)) begin
                            r_state <= ST_DONE;
                            r_gnt   <= '0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_match  <= 1'b0;
                    r_done   <= 1'b0;
                    r_abort  <= 1'b0;
                    r_rr_ptr <= (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                    r_match <= 1'b0;
                    r_done  <= 1'b0;
                    r_abort <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign busy      = (r_state != ST_IDLE);
    assign match     = r_match;
    assign done      = r_done;
    assign done_id   = r_idx;
    assign match_cnt = r_cnt;
    assign abort     = r_abort;

endmodule

// File: tb/tb_seq_det_arbiter.sv
module tb_seq_det_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, din, gnt;
    logic [7:0] len, match_cnt;
    logic       busy, match, done, abort;
    logic [1:0] done_id;

    logic [3:0] req4, din4, gnt4;
    logic [3:0] len4, cnt4;
    logic       busy4, match4, done4, abort4;
    logic [1:0] id4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_det_arbiter u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .len       (len),
        .gnt       (gnt),
        .busy      (busy),
        .match     (match),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt),
        .abort     (abort)
    );

    seq_det_arbiter #(.LEN_W(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .req       (req4),
        .din       (din4),
        .len       (len4),
        .gnt       (gnt4),
        .busy      (busy4),
        .match     (match4),
        .done      (done4),
        .done_id   (id4),
        .match_cnt (cnt4),
        .abort     (abort4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [6:0]  bits7;
        logic [14:0] bits15;
        int          npulse;
        logic [3:0]  rr_exp [4];

        rst = 1'b0; req = '0; din = '0; len = '0;
        req4 = '0; din4 = '0; len4 = '0;
        tick();
        tick();

        // reset state
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cnt", match_cnt, 8'd0);
        chk("rst_id", done_id, 2'd0);
        rst = 1'b1;

        // basic frame, with len/other req changed mid-frame
        req = 4'b0001; len = 8'd7;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        bits7 = 7'b1101101;
        for (int i = 0; i < 7; i++) begin
            din[0] = bits7[6-i];
            if (i == 1) begin
                len = 8'd3;
                req = 4'b0011;
            end
            tick();
            chk($sformatf("t1_match_b%0d", i + 1), match, (i == 3 || i == 6));
            if (i < 6) begin
                chk($sformatf("t1_gnt_b%0d", i + 1), gnt, 4'b0001);
                chk($sformatf("t1_done_b%0d", i + 1), done, 1'b0);
            end
        end
        chk("t1_done", done, 1'b1);
        chk("t1_id", done_id, 2'd0);
        chk("t1_cnt", match_cnt, 8'd2);
        chk("t1_abort", abort, 1'b0);
        chk("t1_gnt_done", gnt, 4'b0000);
        req = '0;
        tick();
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_done", done, 1'b0);

        // zero length
        req = 4'b0010; len = 8'd0;
        tick();
        chk("t2_gnt", gnt, 4'b0000);
        chk("t2_done", done, 1'b1);
        chk("t2_id", done_id, 2'd1);
        chk("t2_cnt", match_cnt, 8'd0);
        req = '0;
        tick();
        chk("t2_idle", busy, 1'b0);

        // abort
        req = 4'b0010; len = 8'd10;
        tick();
        chk("t3_gnt", gnt, 4'b0010);
        din[1] = 1'b1; tick();
        din[1] = 1'b1; tick();
        din[1] = 1'b0; tick();
        req = 4'b0000; din[1] = 1'b1;
        tick();
        chk("t3_done", done, 1'b1);
        chk("t3_abort", abort, 1'b1);
        chk("t3_id", done_id, 2'd1);
        chk("t3_cnt", match_cnt, 8'd0);
        chk("t3_match", match, 1'b0);
        tick();
        chk("t3_abort_clr", abort, 1'b0);

        // reset mid-frame (rr_ptr is 2 here, grant goes to lane 1)
        req = 4'b0010; len = 8'd8;
        tick();
        chk("t4_gnt", gnt, 4'b0010);
        din[1] = 1'b1; tick();
        din[1] = 1'b1; tick();
        din[1] = 1'b0; rst = 1'b0; req = '0;
        tick();
        chk("t4_gnt_rst", gnt, 4'b0000);
        chk("t4_busy_rst", busy, 1'b0);
        chk("t4_done_rst", done, 1'b0);
        chk("t4_id_rst", done_id, 2'd0);
        chk("t4_cnt_rst", match_cnt, 8'd0);
        chk("t4_abort_rst", abort, 1'b0);
        rst = 1'b1;
        tick();
        chk("t4_no_done", done, 1'b0);
        // pointer back at 0: of lanes 1 and 3, lane 1 wins
        req = 4'b1010; len = 8'd1;
        tick();
        chk("t4_rr0", gnt, 4'b0010);
        tick();
        chk("t4_done1", done, 1'b1);
        req = '0;
        tick();
        req = 4'b1000; len = 8'd2;
        tick();
        chk("t4_gnt3", gnt, 4'b1000);
        tick();
        tick();
        chk("t4_done3", done, 1'b1);
        chk("t4_id3", done_id, 2'd3);
        req = '0;
        tick();

        // round robin from reset
        rst = 1'b0; tick(); rst = 1'b1;
        req = 4'b0101; len = 8'd1;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b0001; rr_exp[3] = 4'b0100;
        for (int f = 0; f < 4; f++) begin
            tick();
            chk($sformatf("t5_gnt_f%0d", f), gnt, rr_exp[f]);
            tick();
            chk($sformatf("t5_done_f%0d", f), done, 1'b1);
            chk($sformatf("t5_id_f%0d", f), done_id, (rr_exp[f] == 4'b0001) ? 2'd0 : 2'd2);
            chk($sformatf("t5_dgnt_f%0d", f), gnt, 4'b0000);
            tick();
            chk($sformatf("t5_idle_f%0d", f), busy, 1'b0);
        end
        req = '0;
        tick();

        // narrow counter, long overlapping stream
        req4 = 4'b0001; len4 = 4'd15;
        tick();
        chk("t6_gnt", gnt4, 4'b0001);
        bits15 = 15'b110110110110110;
        npulse = 0;
        for (int i = 0; i < 15; i++) begin
            din4[0] = bits15[14-i];
            tick();
            if (match4) npulse++;
        end
        chk("t6_done", done4, 1'b1);
        chk("t6_cnt", cnt4, 4'd4);
        chk("t6_pulses", npulse, 4);
        req4 = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
